// File: rtl/idex_stage.sv
// ID/EX pipeline register for the pipelined LEGv8 core: captures decoded fields,
// detects load-use hazards, inserts bubbles on stall/flush and tracks pipeline fill.
module idex_stage #(
  parameter int WORD     = 64,
  parameter int REGADDR  = 5,
  parameter int OPCODE   = 11,
  parameter int COUNTER  = 3,
  parameter int STAGEMAX = 4,
  parameter int XZR      = 31
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               flush,
  input  logic [OPCODE-1:0]  id_opcode,
  input  logic [REGADDR-1:0] id_ra,
  input  logic [REGADDR-1:0] id_rb,
  input  logic [REGADDR-1:0] id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_memwrite,
  input  logic [WORD-1:0]    id_a,
  input  logic [WORD-1:0]    id_b,
  input  logic [WORD-1:0]    id_imm,
  input  logic [WORD-1:0]    id_pc,
  output logic               stall,
  output logic [COUNTER-1:0] stage,
  output logic [OPCODE-1:0]  idex_opcode,
  output logic [REGADDR-1:0] idex_ra,
  output logic [REGADDR-1:0] idex_rb,
  output logic [REGADDR-1:0] idex_rd,
  output logic               idex_regwrite,
  output logic               idex_memread,
  output logic               idex_memwrite,
  output logic [WORD-1:0]    idex_a,
  output logic [WORD-1:0]    idex_b,
  output logic [WORD-1:0]    idex_imm,
  output logic [WORD-1:0]    idex_pc
);

  localparam logic [REGADDR-1:0] XZR_ADDR  = REGADDR'(XZR);
  localparam logic [COUNTER-1:0] STAGE_TOP = COUNTER'(STAGEMAX);

  logic hazard;

  // A load into XZR produces nothing a consumer could depend on.
  assign hazard = idex_memread && (idex_rd != XZR_ADDR) &&
                  ((idex_rd == id_ra) || (idex_rd == id_rb));
  assign stall  = hazard && !flush;

  // Fill counter: bubbles occupy stages too, so it ignores stall and flush.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      stage <= '0;
    end else if (stage < STAGE_TOP) begin
      stage <= stage + 1'b1;
    end
  end

  // ID -> EX boundary
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      idex_opcode   <= '0;
      idex_ra       <= XZR_ADDR;
      idex_rb       <= XZR_ADDR;
      idex_rd       <= XZR_ADDR;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_a        <= '0;
      idex_b        <= '0;
      idex_imm      <= '0;
      idex_pc       <= '0;
    end else if (flush || hazard) begin
      idex_opcode   <= '0;
      idex_ra       <= XZR_ADDR;
      idex_rb       <= XZR_ADDR;
      idex_rd       <= XZR_ADDR;
      idex_regwrite <= 1'b0;
      idex_memread  <= 1'b0;
      idex_memwrite <= 1'b0;
      idex_a        <= '0;
      idex_b        <= '0;
      idex_imm      <= '0;
      idex_pc       <= '0;
    end else begin
      idex_opcode   <= id_opcode;
      idex_ra       <= id_ra;
      idex_rb       <= id_rb;
      idex_rd       <= id_rd;
      idex_regwrite <= id_regwrite;
      idex_memread  <= id_memread;
      idex_memwrite <= id_memwrite;
      idex_a        <= id_a;
      idex_b        <= id_b;
      idex_imm      <= id_imm;
      idex_pc       <= id_pc;
    end
  end

endmodule

// File: tb/tb_idex_stage.sv
// Directed bench for idex_stage: reset, capture, load-use stall, XZR, flush, reset mid-stream.
module tb_idex_stage;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_LDUR = 11'h7C2;

  logic        clk = 1'b0;
  logic        nrst;
  logic        flush;
  logic [10:0] id_opcode;
  logic [4:0]  id_ra, id_rb, id_rd;
  logic        id_regwrite, id_memread, id_memwrite;
  logic [63:0] id_a, id_b, id_imm, id_pc;
  logic        stall;
  logic [2:0]  stage;
  logic [10:0] idex_opcode;
  logic [4:0]  idex_ra, idex_rb, idex_rd;
  logic        idex_regwrite, idex_memread, idex_memwrite;
  logic [63:0] idex_a, idex_b, idex_imm, idex_pc;

  int errors = 0;
  int checks = 0;

  idex_stage dut (
    .clk(clk), .nrst(nrst), .flush(flush),
    .id_opcode(id_opcode), .id_ra(id_ra), .id_rb(id_rb), .id_rd(id_rd),
    .id_regwrite(id_regwrite), .id_memread(id_memread), .id_memwrite(id_memwrite),
    .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_pc(id_pc),
    .stall(stall), .stage(stage),
    .idex_opcode(idex_opcode), .idex_ra(idex_ra), .idex_rb(idex_rb), .idex_rd(idex_rd),
    .idex_regwrite(idex_regwrite), .idex_memread(idex_memread), .idex_memwrite(idex_memwrite),
    .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm), .idex_pc(idex_pc)
  );

  always #5 clk = ~clk;

  // Advance one rising edge, then settle away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_id(input logic [10:0] opc, input logic [4:0] ra, input logic [4:0] rb,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic [63:0] a, input logic [63:0] b, input logic [63:0] pc);
    id_opcode = opc; id_ra = ra; id_rb = rb; id_rd = rd;
    id_regwrite = rw; id_memread = mr; id_memwrite = mw;
    id_a = a; id_b = b; id_imm = 64'h10; id_pc = pc;
    #1;
  endtask

  task automatic test_reset();
    nrst = 1'b0; flush = 1'b0;
    set_id(OP_ADD, 5'd2, 5'd3, 5'd1, 1'b1, 1'b0, 1'b0, 64'hAAAA_0000_1111_2222, 64'h3333, 64'h100);
    tick(); tick();
    checks++; if (stage !== 3'd0) begin errors++; $display("FAIL reset_stage got %0d want 0", stage); end
    checks++; if (idex_rd !== 5'd31) begin errors++; $display("FAIL reset_rd got %0d want 31", idex_rd); end
    checks++; if (idex_regwrite !== 1'b0) begin errors++; $display("FAIL reset_regwrite got %0b want 0", idex_regwrite); end
    checks++; if (idex_a !== 64'h0) begin errors++; $display("FAIL reset_a got %0h want 0", idex_a); end
    nrst = 1'b1;
    tick();
    checks++; if (idex_rd !== 5'd1) begin errors++; $display("FAIL add_rd got %0d want 1", idex_rd); end
    checks++; if (idex_regwrite !== 1'b1) begin errors++; $display("FAIL add_regwrite got %0b want 1", idex_regwrite); end
    checks++; if (idex_a !== 64'hAAAA_0000_1111_2222) begin errors++; $display("FAIL add_a got %0h want aaaa000011112222", idex_a); end
    checks++; if (idex_opcode !== OP_ADD) begin errors++; $display("FAIL add_opcode got %0h want %0h", idex_opcode, OP_ADD); end
    checks++; if (stage !== 3'd1) begin errors++; $display("FAIL stage_e1 got %0d want 1", stage); end
    tick();
    checks++; if (stage !== 3'd2) begin errors++; $display("FAIL stage_e2 got %0d want 2", stage); end
    tick();
    checks++; if (stage !== 3'd3) begin errors++; $display("FAIL stage_e3 got %0d want 3", stage); end
    tick();
    checks++; if (stage !== 3'd4) begin errors++; $display("FAIL stage_e4 got %0d want 4", stage); end
    tick();
    checks++; if (stage !== 3'd4) begin errors++; $display("FAIL stage_e5 got %0d want 4", stage); end
    tick();
    checks++; if (stage !== 3'd4) begin errors++; $display("FAIL stage_e6 got %0d want 4", stage); end
  endtask

  task automatic test_load_use();
    set_id(OP_LDUR, 5'd2, 5'd31, 5'd5, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0, 64'h200);
    tick();
    checks++; if (idex_memread !== 1'b1 || idex_rd !== 5'd5) begin errors++; $display("FAIL lu_load got memread=%0b rd=%0d want 1/5", idex_memread, idex_rd); end
    set_id(OP_ADD, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 64'h55, 64'h77, 64'h204);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %0b want 1", stall); end
    tick();
    checks++; if (idex_regwrite !== 1'b0 || idex_rd !== 5'd31) begin errors++; $display("FAIL lu_bubble got rw=%0b rd=%0d want 0/31", idex_regwrite, idex_rd); end
    checks++; if (idex_memread !== 1'b0 || idex_opcode !== 11'h0) begin errors++; $display("FAIL lu_bubble_ctl got mr=%0b op=%0h want 0/0", idex_memread, idex_opcode); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL lu_stall_clear got %0b want 0", stall); end
    tick();
    checks++; if (idex_rd !== 5'd6 || idex_ra !== 5'd5 || idex_pc !== 64'h204) begin errors++; $display("FAIL lu_add got rd=%0d ra=%0d pc=%0h want 6/5/204", idex_rd, idex_ra, idex_pc); end
  endtask

  task automatic test_xzr();
    set_id(OP_LDUR, 5'd2, 5'd31, 5'd31, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0, 64'h300);
    tick();
    set_id(OP_ADD, 5'd31, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 64'h0, 64'h77, 64'h304);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL xzr_stall got %0b want 0", stall); end
    tick();
    checks++; if (idex_rd !== 5'd6 || idex_pc !== 64'h304) begin errors++; $display("FAIL xzr_add got rd=%0d pc=%0h want 6/304", idex_rd, idex_pc); end
  endtask

  task automatic test_flush();
    set_id(OP_LDUR, 5'd2, 5'd31, 5'd5, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0, 64'h400);
    tick();
    set_id(OP_ADD, 5'd5, 5'd7, 5'd6, 1'b1, 1'b0, 1'b0, 64'h55, 64'h77, 64'h404);
    flush = 1'b1; #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL flush_stall got %0b want 0", stall); end
    tick();
    flush = 1'b0;
    checks++; if (idex_rd !== 5'd31 || idex_regwrite !== 1'b0 || idex_pc !== 64'h0) begin errors++; $display("FAIL flush_bubble got rd=%0d rw=%0b pc=%0h want 31/0/0", idex_rd, idex_regwrite, idex_pc); end
    set_id(OP_SUB, 5'd2, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0, 64'h9, 64'h3, 64'h500);
    tick();
    checks++; if (idex_rd !== 5'd9 || idex_opcode !== OP_SUB) begin errors++; $display("FAIL flush_next got rd=%0d op=%0h want 9/%0h", idex_rd, idex_opcode, OP_SUB); end
  endtask

  task automatic test_back_to_back();
    set_id(OP_LDUR, 5'd2, 5'd31, 5'd5, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0, 64'h600);
    tick();
    set_id(OP_ADD, 5'd2, 5'd3, 5'd6, 1'b1, 1'b0, 1'b0, 64'hBEEF, 64'hCAFE, 64'h604);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0b want 0", stall); end
    tick();
    checks++; if (idex_rd !== 5'd6 || idex_b !== 64'hCAFE) begin errors++; $display("FAIL b2b_add got rd=%0d b=%0h want 6/cafe", idex_rd, idex_b); end
    // Dependent chain of loads: each load stalls its consumer exactly once.
    set_id(OP_LDUR, 5'd2, 5'd31, 5'd5, 1'b1, 1'b1, 1'b0, 64'h20, 64'h0, 64'h700);
    tick();
    set_id(OP_LDUR, 5'd5, 5'd31, 5'd8, 1'b1, 1'b1, 1'b0, 64'h0, 64'h0, 64'h704);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL chain_stall1 got %0b want 1", stall); end
    tick();
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL chain_clear1 got %0b want 0", stall); end
    tick();
    checks++; if (idex_rd !== 5'd8 || idex_memread !== 1'b1) begin errors++; $display("FAIL chain_load2 got rd=%0d mr=%0b want 8/1", idex_rd, idex_memread); end
    set_id(OP_ADD, 5'd1, 5'd8, 5'd9, 1'b1, 1'b0, 1'b0, 64'h1, 64'h0, 64'h708);
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL chain_stall2 got %0b want 1", stall); end
    tick();
    tick();
    checks++; if (idex_rd !== 5'd9 || stall !== 1'b0) begin errors++; $display("FAIL chain_add got rd=%0d stall=%0b want 9/0", idex_rd, stall); end
  endtask

  task automatic test_reset_mid();
    checks++; if (stage !== 3'd4 || idex_regwrite !== 1'b1) begin errors++; $display("FAIL mid_pre got stage=%0d rw=%0b want 4/1", stage, idex_regwrite); end
    #2;
    nrst = 1'b0;
    #1;
    checks++; if (stage !== 3'd0 || idex_regwrite !== 1'b0) begin errors++; $display("FAIL mid_async got stage=%0d rw=%0b want 0/0", stage, idex_regwrite); end
    checks++; if (idex_rd !== 5'd31) begin errors++; $display("FAIL mid_rd got %0d want 31", idex_rd); end
    tick();
    nrst = 1'b1;
    tick();
    checks++; if (stage !== 3'd1) begin errors++; $display("FAIL mid_restart got %0d want 1", stage); end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_xzr();
    test_flush();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/idex_stage.md
Name: idex_stage

Overview:
- ID/EX pipeline register for the pipelined LEGv8 core. Captures decoded instruction fields and operands from the ID stage and presents them to EX and to the forwarding unit as the idex_* signals.
- Owns the pipeline fill counter (stage) that gates forwarding during start-up.
- Detects load-use hazards, requests an IF/ID stall, and inserts bubbles on stall or on a branch flush.

Parameters:
- WORD, 64, data/PC/immediate width
- REGADDR, 5, register address width
- OPCODE, 11, opcode field width
- COUNTER, 3, width of stage counter
- STAGEMAX, 4, saturation value of stage counter
- XZR, 31, zero-register index

Ports:
- clk  in  1  core clock, all state on rising edge
- nrst  in  1  asynchronous active-low reset
- flush  in  1  branch taken: squash instruction in ID
- id_opcode  in  OPCODE  decoded opcode
- id_ra  in  REGADDR  first source register
- id_rb  in  REGADDR  second source register
- id_rd  in  REGADDR  destination register
- id_regwrite  in  1  instruction writes rd
- id_memread  in  1  instruction is a load
- id_memwrite  in  1  instruction is a store
- id_a  in  WORD  register-file read A
- id_b  in  WORD  register-file read B
- id_imm  in  WORD  sign-extended immediate
- id_pc  in  WORD  PC of instruction in ID
- stall  out  1  hold PC and IF/ID this cycle (combinational)
- stage  out  COUNTER  pipeline fill count, to forwarding unit
- idex_opcode  out  OPCODE  registered opcode
- idex_ra  out  REGADDR  registered source A
- idex_rb  out  REGADDR  registered source B
- idex_rd  out  REGADDR  registered destination
- idex_regwrite  out  1  registered control
- idex_memread  out  1  registered control
- idex_memwrite  out  1  registered control
- idex_a  out  WORD  registered operand A
- idex_b  out  WORD  registered operand B
- idex_imm  out  WORD  registered immediate
- idex_pc  out  WORD  registered PC

Behaviour:
- Reset (nrst low, asynchronous):
  - stage=0.
  - Every idex_* output holds the bubble value: all controls 0, opcode 0, ra=rb=rd=XZR, data fields 0.
  - Outputs stay at these values while nrst is low.
  - The first capture happens on the first rising edge after nrst goes high.
- Hazard (combinational): hazard = idex_memread && idex_rd!=XZR && (idex_rd==id_ra || idex_rd==id_rb).
- stall = hazard && !flush. A flushed ID instruction is discarded, so it is never stalled.
- Update each rising edge, priority flush > hazard > load:
  - flush=1: load the bubble.
  - hazard=1: load the bubble. ID/IF hold by stall, so the same instruction is re-presented next cycle.
  - otherwise: load all id_* fields into idex_*. Latency is 1 cycle.
- A stall lasts exactly one cycle per load, because the bubble clears idex_memread.
- Back-to-back loads that depend on each other stall once each.
- stage counter:
  - Increments by 1 every rising edge after reset, saturating at STAGEMAX; it never wraps.
  - Counts regardless of stall or flush, because bubbles occupy stages too.
- Bubble opcode 0 must not match the branch mask. A bubble writes no register, so forwarding ignores it.
- No handshake beyond stall. Downstream EX always accepts.

Test Plan:
- Reset, then release with ADD X1,X2,X3 in ID (ra=2, rb=3, rd=1, regwrite=1) -> after 1 edge idex_rd=1, idex_regwrite=1, idex_a=id_a. stage reads 1,2,3,4,4,4 on successive edges.
- LDUR X5 followed by ADD X6,X5,X7 -> cycle after load capture: stall=1. Next edge loads the bubble (idex_regwrite=0, idex_rd=31). ADD is captured on the following edge, and stall=0.
- LDUR X31 followed by ADD X6,X31,X7 -> stall=0. ADD is captured immediately.
- LDUR X5 in EX, dependent ADD in ID, flush=1 -> stall=0. Bubble loaded, and the ADD never appears in idex_*.
- Non-dependent LDUR X5 then ADD X6,X2,X3 -> no stall, back-to-back capture.
- Assert nrst low mid-stream while stage=4 and idex_regwrite=1 -> immediately stage=0 and idex_regwrite=0 without waiting for a clock edge. Count restarts from 1 after release.
